mem_host: RTL
=============

MEM_HOST -- requirements
Module: mem_host

Interface
REQ-001 SHALL have parameter POLL_ADDR, default 64'h8000_0000_0000_0000, target register address whose bit 0 is the halted flag.
REQ-002 SHALL have parameter POLL_LIMIT, default 16'd1000, maximum halted-poll reads before a timeout error.
REQ-003 SHALL have port i_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port i_req_valid  input  1  upstream request valid.
REQ-006 SHALL have port o_req_ready  output  1  request accepted on a cycle where i_req_valid and o_req_ready are both 1.
REQ-007 SHALL have port i_req_op  input  2  request op: 0=NOP, 1=READ, 2=WRITE, 3=POLL.
REQ-008 SHALL have port i_req_addr  input  64  request address; bit 63 set selects a target register.
REQ-009 SHALL have port i_req_data  input  64  write data.
REQ-010 SHALL have port o_rsp_valid  output  1  response valid.
REQ-011 SHALL have port i_rsp_ready  input  1  response consumed on a cycle where o_rsp_valid and i_rsp_ready are both 1.
REQ-012 SHALL have port o_rsp_data  output  64  read data, or poll count.
REQ-013 SHALL have port o_rsp_err  output  1  1 = NOP request, no-pending timeout, or poll timeout.
REQ-014 SHALL have port o_mem_op  output  2  target op: 0=NOP, 1=READ, 2=WRITE.
REQ-015 SHALL have port o_mem_addr  output  64  target address.
REQ-016 SHALL have port o_mem_data  output  64  target write data.
REQ-017 SHALL have port i_mem_data  input  64  target read data.
REQ-018 SHALL have port i_mem_op_pending  input  1  target read-in-progress flag.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, CAPTURE, RESP; o_req_ready = 1 only in IDLE.
REQ-020 On accept: latch op, addr, data; NOP -> RESP with err=1 and no target op; any other op -> ISSUE.
REQ-021 SHALL drive o_mem_op non-zero for exactly one cycle, the ISSUE cycle, and 0 in every other cycle.
REQ-022 POLL SHALL issue READ to POLL_ADDR; READ and WRITE issue to the latched address.
REQ-023 ISSUE exits: WRITE -> RESP; READ with addr[63]=1, or POLL -> CAPTURE; READ with addr[63]=0 -> WAIT.
REQ-024 WAIT: i_mem_op_pending=1 -> CAPTURE; pending 0 for 2 consecutive WAIT cycles -> RESP with err=1, data 0.
REQ-025 CAPTURE SHALL register i_mem_data. READ -> RESP, data = i_mem_data, err=0.
REQ-026 CAPTURE for POLL, bit 0 = 1 -> RESP, err=0, data = poll count including this read.
REQ-027 CAPTURE for POLL, bit 0 = 0, count < POLL_LIMIT -> increment the 16-bit count and return to ISSUE.
REQ-028 CAPTURE for POLL, bit 0 = 0, count = POLL_LIMIT -> RESP, err=1, data = POLL_LIMIT.
REQ-029 The poll count SHALL reset to 0 on every accept and SHALL never wrap.
REQ-030 Latency, with the accept cycle as c0, o_rsp_valid first high at: WRITE c2; register READ c3; memory READ c4; NOP c1.
REQ-031 Each POLL iteration SHALL take 2 cycles (ISSUE, CAPTURE).
REQ-032 RESP: o_rsp_valid=1 and o_rsp_data/o_rsp_err held stable until consumed, then -> IDLE; no new request accepted the same cycle.
REQ-033 o_mem_addr/o_mem_data SHALL hold latched values from ISSUE until the next accept.
REQ-034 WRITE responses SHALL carry data 0, err=0.

Reset
REQ-035 When i_rst_n=0 at a clock edge, next cycle: state IDLE, o_mem_op=0, o_mem_addr=0, o_mem_data=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, poll count 0, o_req_ready=1.
REQ-036 Reset mid-operation (any state) SHALL abort with no response and no further target op.

Verification
REQ-037 WRITE addr 0x10 data 0xDEAD -> one-cycle o_mem_op=2, addr 0x10, data 0xDEAD; o_rsp_valid at c2, err=0.
REQ-038 Memory READ addr 0x20, responder returns 0x1234 one cycle after pending -> pending seen c2, o_rsp_data=0x1234 at c4, err=0.
REQ-039 POLL, halted rises on 3rd read -> three 2-cycle ISSUE/CAPTURE iterations; rsp data=3, err=0.
REQ-040 POLL with POLL_LIMIT=4 and halted never set -> 5 target reads, rsp err=1, data=4.
REQ-041 Memory READ with pending never asserted -> rsp err=1 at c4; o_rsp_valid held while i_rsp_ready=0 for 3 cycles.
REQ-042 i_rst_n=0 during WAIT -> next cycle IDLE, o_rsp_valid=0, o_mem_op=0; new WRITE then completes normally.

Source files
------------

// File: rtl/mem_host.sv
// mem_host: single-request host that issues READ/WRITE/POLL operations to a target
// and returns one response per accepted request.
module mem_host #(
    parameter logic [63:0] POLL_ADDR  = 64'h8000_0000_0000_0000,
    parameter logic [15:0] POLL_LIMIT = 16'd1000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [1:0]  i_req_op,
    input  logic [63:0] i_req_addr,
    input  logic [63:0] i_req_data,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [63:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic [1:0]  o_mem_op,
    output logic [63:0] o_mem_addr,
    output logic [63:0] o_mem_data,
    input  logic [63:0] i_mem_data,
    input  logic        i_mem_op_pending
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;
    localparam logic [1:0] NOP = 2'd0, READ = 2'd1, WRITE = 2'd2, POLL = 2'd3;
    state_t      state, state_nx;
    logic [1:0]  op;
    logic [15:0] count;
    logic        waited;
    assign o_req_ready = state == IDLE;
    assign o_rsp_valid = state == RESP;
    assign o_mem_op    = state == ISSUE ? (op == POLL ? READ : op) : NOP;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_req_valid) state_nx = i_req_op == NOP ? RESP : ISSUE;
            ISSUE:   state_nx = op == WRITE ? RESP : (op == POLL || o_mem_addr[63]) ? CAPTURE : WAIT;
            WAIT:    state_nx = i_mem_op_pending ? CAPTURE : waited ? RESP : WAIT;
            CAPTURE: state_nx = (op == READ || i_mem_data[0] || count == POLL_LIMIT) ? RESP : ISSUE;
            RESP:    if (i_rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            op         <= NOP;
            count      <= '0;
            waited     <= 1'b0;
            o_mem_addr <= '0;
            o_mem_data <= '0;
            o_rsp_data <= '0;
            o_rsp_err  <= 1'b0;
        end else begin
            state  <= state_nx;
            // marks the second consecutive WAIT cycle for the no-pending timeout
            waited <= state == WAIT;
            if (state == IDLE && i_req_valid) begin
                op         <= i_req_op;
                o_mem_addr <= i_req_op == POLL ? POLL_ADDR : i_req_addr;
                o_mem_data <= i_req_data;
                count      <= '0;
                o_rsp_data <= '0;
                o_rsp_err  <= i_req_op == NOP;
            end
            if (state == WAIT && !i_mem_op_pending && waited) o_rsp_err <= 1'b1;
            if (state == CAPTURE) begin
                if (op == READ) o_rsp_data <= i_mem_data;
                else if (i_mem_data[0]) o_rsp_data <= 64'(count) + 64'd1;
                else if (count == POLL_LIMIT) begin
                    o_rsp_data <= 64'(POLL_LIMIT);
                    o_rsp_err  <= 1'b1;
                end else count <= count + 16'd1;
            end
        end
    end
endmodule
